// File: rtl/bram_write_arbiter.sv
// Two-requester round-robin write arbiter for one BlockRam write port.
// Includes a clear engine that sweeps every element to ClearValue.
//
// Ports:
//   i_CLK, i_RST          clock, synchronous active-high reset
//   i_clear_start         request a full-memory clear
//   o_clear_busy          sweep in progress
//   o_clear_done          one-cycle pulse when the sweep completes
//   i_a_valid/o_a_ready   requester A handshake (ready is combinational)
//   i_a_addr/i_a_data     requester A write address / data
//   i_b_*/o_b_ready       requester B, same as A
//   o_write_en/addr/data  registered BlockRam write port
//   o_addr_err            one-cycle pulse: accepted write had addr >= NumElements
module bram_write_arbiter #(
   parameter int AddrBusSize = 9,
   parameter int NumElements = 512,
   parameter int ElementSize = 8,
   parameter logic [ElementSize-1:0] ClearValue = '0
) (
   input  logic                   i_CLK,
   input  logic                   i_RST,
   input  logic                   i_clear_start,
   output logic                   o_clear_busy,
   output logic                   o_clear_done,
   input  logic                   i_a_valid,
   output logic                   o_a_ready,
   input  logic [AddrBusSize-1:0] i_a_addr,
   input  logic [ElementSize-1:0] i_a_data,
   input  logic                   i_b_valid,
   output logic                   o_b_ready,
   input  logic [AddrBusSize-1:0] i_b_addr,
   input  logic [ElementSize-1:0] i_b_data,
   output logic                   o_write_en,
   output logic [AddrBusSize-1:0] o_write_addr,
   output logic [ElementSize-1:0] o_write_data,
   output logic                   o_addr_err
);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   localparam logic [AddrBusSize-1:0] LastAddr =
      AddrBusSize'(NumElements - 1);
   // One extra bit so NumElements == 2**AddrBusSize is representable.
   localparam logic [AddrBusSize:0] Depth =
      (AddrBusSize + 1)'(NumElements);

   state_t                 state;
   logic                   last_grant_b;
   logic [AddrBusSize-1:0] clr_cnt;

   logic                   grant_a;
   logic                   open_win;
   logic                   xfer_a;
   logic                   xfer_b;
   logic [AddrBusSize-1:0] sel_addr;
   logic [ElementSize-1:0] sel_data;
   logic                   in_range;

   // Exactly one side is granted every cycle. A lone requester wins;
   // on a tie (both or neither valid) the side not served last wins.
   always_comb begin
      grant_a  = (i_a_valid ^ i_b_valid) ? i_a_valid : last_grant_b;
      open_win = (state == ST_IDLE) & ~i_clear_start & ~i_RST;
      o_a_ready = open_win & grant_a;
      o_b_ready = open_win & ~grant_a;
      xfer_a   = i_a_valid & o_a_ready;
      xfer_b   = i_b_valid & o_b_ready;
      sel_addr = xfer_a ? i_a_addr : i_b_addr;
      sel_data = xfer_a ? i_a_data : i_b_data;
      in_range = {1'b0, sel_addr} < Depth;
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state        <= ST_IDLE;
         last_grant_b <= 1'b1;
         clr_cnt      <= '0;
         o_clear_busy <= 1'b0;
         o_clear_done <= 1'b0;
         o_write_en   <= 1'b0;
         o_write_addr <= '0;
         o_write_data <= '0;
         o_addr_err   <= 1'b0;
      end else begin
         o_write_en   <= 1'b0;
         o_addr_err   <= 1'b0;
         o_clear_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (i_clear_start) begin
                  state        <= ST_CLEAR;
                  clr_cnt      <= '0;
                  o_clear_busy <= 1'b1;
                  o_write_en   <= 1'b1;
                  o_write_addr <= '0;
                  o_write_data <= ClearValue;
               end else if (xfer_a | xfer_b) begin
                  last_grant_b <= xfer_b;
                  if (in_range) begin
                     o_write_en   <= 1'b1;
                     o_write_addr <= sel_addr;
                     o_write_data <= sel_data;
                  end else begin
                     // Handshake completes but the write is dropped.
                     o_addr_err <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               // clr_cnt mirrors the address currently on the port;
               // stopping at LastAddr keeps it from ever wrapping.
               if (clr_cnt == LastAddr) begin
                  state        <= ST_IDLE;
                  clr_cnt      <= '0;
                  o_clear_busy <= 1'b0;
                  o_clear_done <= 1'b1;
               end else begin
                  clr_cnt      <= clr_cnt + 1'b1;
                  o_write_en   <= 1'b1;
                  o_write_addr <= clr_cnt + 1'b1;
                  o_write_data <= ClearValue;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed bench for bram_write_arbiter.
// Table vectors for arbitration, plus sequences for clear and reset abort.
module tb_bram_write_arbiter;

   logic       i_CLK = 1'b0;
   logic       i_RST = 1'b1;
   logic       i_clear_start = 1'b0;
   logic       o_clear_busy;
   logic       o_clear_done;
   logic       i_a_valid = 1'b0;
   logic       o_a_ready;
   logic [3:0] i_a_addr = '0;
   logic [7:0] i_a_data = '0;
   logic       i_b_valid = 1'b0;
   logic       o_b_ready;
   logic [3:0] i_b_addr = '0;
   logic [7:0] i_b_data = '0;
   logic       o_write_en;
   logic [3:0] o_write_addr;
   logic [7:0] o_write_data;
   logic       o_addr_err;

   int n_pass = 0;
   int n_total = 0;

   always #5 i_CLK = ~i_CLK;

   bram_write_arbiter #(
      .AddrBusSize(4),
      .NumElements(12),
      .ElementSize(8),
      .ClearValue(8'hFF)
   ) dut (
      .i_CLK(i_CLK),
      .i_RST(i_RST),
      .i_clear_start(i_clear_start),
      .o_clear_busy(o_clear_busy),
      .o_clear_done(o_clear_done),
      .i_a_valid(i_a_valid),
      .o_a_ready(o_a_ready),
      .i_a_addr(i_a_addr),
      .i_a_data(i_a_data),
      .i_b_valid(i_b_valid),
      .o_b_ready(o_b_ready),
      .i_b_addr(i_b_addr),
      .i_b_data(i_b_data),
      .o_write_en(o_write_en),
      .o_write_addr(o_write_addr),
      .o_write_data(o_write_data),
      .o_addr_err(o_addr_err)
   );

   typedef struct {
      logic       rst;
      logic       av;
      logic [3:0] aa;
      logic [7:0] ad;
      logic       bv;
      logic [3:0] ba;
      logic [7:0] bd;
      logic       ar;
      logic       br;
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      logic       err;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic chk_port(input string tag, input logic we,
                           input logic [3:0] wa, input logic [7:0] wd,
                           input logic busy, input logic done);
      chk({tag, " we"}, 32'(o_write_en), 32'(we));
      chk({tag, " wa"}, 32'(o_write_addr), 32'(wa));
      chk({tag, " wd"}, 32'(o_write_data), 32'(wd));
      chk({tag, " busy"}, 32'(o_clear_busy), 32'(busy));
      chk({tag, " done"}, 32'(o_clear_done), 32'(done));
   endtask

   initial begin
      //          rst av aa     ad     bv ba     bd     ar br we wa     wd     err
      vecs[0]  = '{1, 1, 4'd3,  8'h11, 1, 4'd4,  8'h22, 0, 0, 0, 4'd0,  8'h00, 0};
      vecs[1]  = '{1, 1, 4'd3,  8'h11, 1, 4'd4,  8'h22, 0, 0, 0, 4'd0,  8'h00, 0};
      vecs[2]  = '{0, 1, 4'd1,  8'h5A, 1, 4'd2,  8'h6B, 1, 0, 1, 4'd1,  8'h5A, 0};
      vecs[3]  = '{0, 1, 4'd3,  8'h11, 0, 4'd0,  8'h00, 1, 0, 1, 4'd3,  8'h11, 0};
      vecs[4]  = '{0, 1, 4'd4,  8'h22, 0, 4'd0,  8'h00, 1, 0, 1, 4'd4,  8'h22, 0};
      vecs[5]  = '{0, 1, 4'd5,  8'h33, 0, 4'd0,  8'h00, 1, 0, 1, 4'd5,  8'h33, 0};
      vecs[6]  = '{0, 0, 4'd0,  8'h00, 0, 4'd0,  8'h00, 0, 1, 0, 4'd5,  8'h33, 0};
      vecs[7]  = '{0, 0, 4'd0,  8'h00, 1, 4'd7,  8'h77, 0, 1, 1, 4'd7,  8'h77, 0};
      vecs[8]  = '{0, 1, 4'd8,  8'h81, 1, 4'd9,  8'h91, 1, 0, 1, 4'd8,  8'h81, 0};
      vecs[9]  = '{0, 1, 4'd8,  8'h81, 1, 4'd9,  8'h91, 0, 1, 1, 4'd9,  8'h91, 0};
      vecs[10] = '{0, 1, 4'd8,  8'h81, 1, 4'd11, 8'hB2, 1, 0, 1, 4'd8,  8'h81, 0};
      vecs[11] = '{0, 1, 4'd10, 8'hA2, 1, 4'd11, 8'hB2, 0, 1, 1, 4'd11, 8'hB2, 0};
      vecs[12] = '{0, 0, 4'd0,  8'h00, 1, 4'd2,  8'h12, 0, 1, 1, 4'd2,  8'h12, 0};
      vecs[13] = '{0, 0, 4'd0,  8'h00, 1, 4'd3,  8'h13, 0, 1, 1, 4'd3,  8'h13, 0};
      vecs[14] = '{0, 1, 4'd4,  8'h44, 1, 4'd5,  8'h55, 1, 0, 1, 4'd4,  8'h44, 0};
      vecs[15] = '{0, 1, 4'd13, 8'hDD, 0, 4'd0,  8'h00, 1, 0, 0, 4'd4,  8'h44, 1};
      vecs[16] = '{0, 0, 4'd0,  8'h00, 0, 4'd0,  8'h00, 0, 1, 0, 4'd4,  8'h44, 0};
      vecs[17] = '{0, 1, 4'd11, 8'hEE, 0, 4'd0,  8'h00, 1, 0, 1, 4'd11, 8'hEE, 0};
      vecs[18] = '{0, 1, 4'd12, 8'h01, 0, 4'd0,  8'h00, 1, 0, 0, 4'd11, 8'hEE, 1};
      vecs[19] = '{0, 0, 4'd0,  8'h00, 0, 4'd0,  8'h00, 0, 1, 0, 4'd11, 8'hEE, 0};

      #1;
      for (int i = 0; i < 20; i++) begin
         i_RST     = vecs[i].rst;
         i_a_valid = vecs[i].av;
         i_a_addr  = vecs[i].aa;
         i_a_data  = vecs[i].ad;
         i_b_valid = vecs[i].bv;
         i_b_addr  = vecs[i].ba;
         i_b_data  = vecs[i].bd;
         #1;
         chk($sformatf("v%0d a_ready", i), 32'(o_a_ready), 32'(vecs[i].ar));
         chk($sformatf("v%0d b_ready", i), 32'(o_b_ready), 32'(vecs[i].br));
         tick();
         chk_port($sformatf("v%0d", i), vecs[i].we, vecs[i].wa,
                  vecs[i].wd, 1'b0, 1'b0);
         chk($sformatf("v%0d addr_err", i), 32'(o_addr_err), 32'(vecs[i].err));
      end

      // Clear with A valid in the same cycle, plus a repeat request mid-sweep.
      i_a_valid = 1'b0;
      i_b_valid = 1'b0;
      i_clear_start = 1'b1;
      i_a_valid = 1'b1;
      i_a_addr  = 4'd6;
      i_a_data  = 8'h66;
      #1;
      chk("clr start a_ready", 32'(o_a_ready), 32'd0);
      chk("clr start b_ready", 32'(o_b_ready), 32'd0);
      tick();
      i_clear_start = 1'b0;
      chk_port("clr k0", 1'b1, 4'd0, 8'hFF, 1'b1, 1'b0);
      for (int k = 1; k < 12; k++) begin
         if (k == 5) i_clear_start = 1'b1;
         #1;
         chk($sformatf("clr k%0d a_ready", k), 32'(o_a_ready), 32'd0);
         tick();
         i_clear_start = 1'b0;
         chk_port($sformatf("clr k%0d", k), 1'b1, 4'(k), 8'hFF, 1'b1, 1'b0);
      end
      #1;
      chk("clr last a_ready", 32'(o_a_ready), 32'd0);
      tick();
      chk_port("clr done", 1'b0, 4'd11, 8'hFF, 1'b0, 1'b1);
      chk("clr done a_ready", 32'(o_a_ready), 32'd1);
      tick();
      chk_port("post clr write", 1'b1, 4'd6, 8'h66, 1'b0, 1'b0);
      i_a_valid = 1'b0;

      // Reset in the middle of a sweep aborts it without a done pulse.
      i_clear_start = 1'b1;
      tick();
      i_clear_start = 1'b0;
      chk_port("abort k0", 1'b1, 4'd0, 8'hFF, 1'b1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         if (k == 3) i_clear_start = 1'b1;
         tick();
         i_clear_start = 1'b0;
         chk_port($sformatf("abort k%0d", k), 1'b1, 4'(k), 8'hFF, 1'b1, 1'b0);
      end
      i_RST = 1'b1;
      i_a_valid = 1'b1;
      #1;
      chk("abort rst a_ready", 32'(o_a_ready), 32'd0);
      tick();
      chk_port("abort rst", 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
      chk("abort rst err", 32'(o_addr_err), 32'd0);
      i_RST = 1'b0;
      i_a_valid = 1'b0;
      tick();
      chk_port("abort after", 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
      i_a_valid = 1'b1;
      i_a_addr  = 4'd1;
      i_a_data  = 8'h31;
      i_b_valid = 1'b1;
      i_b_addr  = 4'd2;
      i_b_data  = 8'h32;
      #1;
      chk("post rst tie a_ready", 32'(o_a_ready), 32'd1);
      chk("post rst tie b_ready", 32'(o_b_ready), 32'd0);
      tick();
      chk_port("post rst tie", 1'b1, 4'd1, 8'h31, 1'b0, 1'b0);
      i_a_valid = 1'b0;
      i_b_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
